// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path: SPI opcodes, the command
// decoder state encoding and the default framebuffer geometry.
package fb_pkg;

    // 320x240 pixels, one byte each
    localparam int FB_WORDS  = 76800;
    localparam int FB_ADDR_W = 17;

    localparam logic [7:0] OP_FB_WRITE  = 8'h01;
    localparam logic [7:0] OP_PAL_WRITE = 8'h02;
    localparam logic [7:0] OP_STATUS    = 8'h03;

    typedef enum logic [3:0] {
        OPCODE,
        ADDR2,
        ADDR1,
        ADDR0,
        FB_DATA,
        PAL_IDX,
        PAL_R,
        PAL_G,
        PAL_B,
        STATUS,
        DISCARD
    } fb_state_t;

    // Map the first byte of a transaction to the state that handles the rest
    function automatic fb_state_t decode_opcode(input logic [7:0] op);
        fb_state_t next;
        case (op)
            OP_FB_WRITE:  next = ADDR2;
            OP_PAL_WRITE: next = PAL_IDX;
            OP_STATUS:    next = STATUS;
            default:      next = DISCARD;
        endcase
        return next;
    endfunction

    // Status byte returned to the SPI master on a status read
    function automatic logic [7:0] status_byte(input logic vblank_s, input logic hblank_s);
        return {6'b0, vblank_s, hblank_s};
    endfunction

endpackage

// File: rtl/fb_write_engine_if.sv
// Bus bundle between the SPI byte stream, the status return path and the
// framebuffer / palette write ports. The engine uses the master view; the
// SPI slave and memories (or a testbench) use the slave view.
interface fb_write_engine_if #(
    parameter int ADDR_W = 17
) ();

    // SPI side
    logic              cs_active;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [7:0]        tx_byte;

    // Framebuffer write port
    logic [ADDR_W-1:0] rgb_addr;
    logic [7:0]        rgb_in;
    logic              wren_rgb;

    // Palette write port
    logic [7:0]        palette_addr;
    logic [23:0]       palette_in;
    logic              wren_palette;

    // One-cycle marker when the last framebuffer byte is written
    logic              frame_done;

    modport master (
        input  cs_active,
        input  rx_byte,
        input  rx_valid,
        output tx_byte,
        output rgb_addr,
        output rgb_in,
        output wren_rgb,
        output palette_addr,
        output palette_in,
        output wren_palette,
        output frame_done
    );

    modport slave (
        output cs_active,
        output rx_byte,
        output rx_valid,
        input  tx_byte,
        input  rgb_addr,
        input  rgb_in,
        input  wren_rgb,
        input  palette_addr,
        input  palette_in,
        input  wren_palette,
        input  frame_done
    );

endinterface

// File: rtl/fb_write_engine_sync_2ff.sv
// Two-flop synchronizer for a single slow-changing level crossing into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Shift the asynchronous level through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/fb_write_engine.sv
// SPI command decoder that turns a byte stream into framebuffer writes,
// palette writes and status reads. All write strobes are registered, so a
// byte accepted on one edge produces its strobe in the following cycle.
module fb_write_engine #(
    parameter int FB_WORDS = fb_pkg::FB_WORDS,
    parameter int ADDR_W   = fb_pkg::FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hblank,
    input  logic              vblank,
    fb_write_engine_if.master bus
);

    import fb_pkg::*;

    localparam logic [31:0]       FB_WORDS_U = 32'(FB_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);

    fb_state_t state_q, state_d;

    logic              hblank_s;
    logic              vblank_s;

    // After reset, bytes are ignored until chip select has been seen idle once
    logic              armed_q;
    logic              accept;

    logic              fb_wr;
    logic              pal_wr;
    logic              status_load;

    logic [15:0]       addr_hi_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              in_range;
    logic              at_last;

    logic [7:0]        pal_idx_q;
    logic [7:0]        pal_r_q;
    logic [7:0]        pal_g_q;

    logic [ADDR_W-1:0] rgb_addr_q;
    logic [7:0]        rgb_in_q;
    logic              wren_rgb_q;
    logic [7:0]        palette_addr_q;
    logic [23:0]       palette_in_q;
    logic              wren_palette_q;
    logic [7:0]        tx_byte_q;
    logic              frame_done_q;

    sync_2ff u_sync_hblank (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hblank),
        .q     (hblank_s)
    );

    sync_2ff u_sync_vblank (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vblank),
        .q     (vblank_s)
    );

    assign accept   = bus.rx_valid && bus.cs_active && armed_q;
    assign in_range = 32'(wr_addr_q) < FB_WORDS_U;
    assign at_last  = (wr_addr_q == LAST_ADDR);

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OPCODE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the single-cycle actions tied to the accepted byte
    always_comb begin
        state_d     = state_q;
        fb_wr       = 1'b0;
        pal_wr      = 1'b0;
        status_load = 1'b0;
        if (!bus.cs_active) begin
            state_d = OPCODE;
        end else if (accept) begin
            case (state_q)
                OPCODE: begin
                    state_d     = decode_opcode(bus.rx_byte);
                    status_load = (bus.rx_byte == OP_STATUS);
                end
                ADDR2:   state_d = ADDR1;
                ADDR1:   state_d = ADDR0;
                ADDR0:   state_d = FB_DATA;
                FB_DATA: fb_wr   = 1'b1;
                PAL_IDX: state_d = PAL_R;
                PAL_R:   state_d = PAL_G;
                PAL_G:   state_d = PAL_B;
                PAL_B: begin
                    pal_wr  = 1'b1;
                    state_d = PAL_R;
                end
                STATUS:  state_d = STATUS;
                DISCARD: state_d = DISCARD;
                default: state_d = OPCODE;
            endcase
        end
    end

    // Arm the decoder once chip select is seen idle after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else if (!bus.cs_active) begin
            armed_q <= 1'b1;
        end
    end

    // Collect address and palette colour bytes as they arrive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hi_q <= '0;
            wr_addr_q <= '0;
            pal_idx_q <= '0;
            pal_r_q   <= '0;
            pal_g_q   <= '0;
        end else begin
            if (accept) begin
                case (state_q)
                    ADDR2:   addr_hi_q[15:8] <= bus.rx_byte;
                    ADDR1:   addr_hi_q[7:0]  <= bus.rx_byte;
                    ADDR0:   wr_addr_q       <= ADDR_W'({addr_hi_q, bus.rx_byte});
                    PAL_IDX: pal_idx_q       <= bus.rx_byte;
                    PAL_R:   pal_r_q         <= bus.rx_byte;
                    PAL_G:   pal_g_q         <= bus.rx_byte;
                    default: ;
                endcase
            end
            if (fb_wr) begin
                wr_addr_q <= at_last ? '0 : wr_addr_q + ADDR_W'(1);
            end
            if (pal_wr) begin
                pal_idx_q <= pal_idx_q + 8'd1;
            end
        end
    end

    // Registered write ports: strobes last one cycle, address/data hold afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_addr_q     <= '0;
            rgb_in_q       <= '0;
            wren_rgb_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            palette_addr_q <= '0;
            palette_in_q   <= '0;
            wren_palette_q <= 1'b0;
        end else begin
            wren_rgb_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            wren_palette_q <= 1'b0;
            if (fb_wr) begin
                rgb_addr_q   <= wr_addr_q;
                rgb_in_q     <= bus.rx_byte;
                wren_rgb_q   <= in_range;
                frame_done_q <= at_last;
            end
            if (pal_wr) begin
                palette_addr_q <= pal_idx_q;
                palette_in_q   <= {pal_r_q, pal_g_q, bus.rx_byte};
                wren_palette_q <= 1'b1;
            end
        end
    end

    // Status byte is captured right after the opcode and cleared when CS idles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_q <= '0;
        end else if (!bus.cs_active) begin
            tx_byte_q <= '0;
        end else if (status_load) begin
            tx_byte_q <= status_byte(vblank_s, hblank_s);
        end
    end

    assign bus.rgb_addr     = rgb_addr_q;
    assign bus.rgb_in       = rgb_in_q;
    assign bus.wren_rgb     = wren_rgb_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.palette_addr = palette_addr_q;
    assign bus.palette_in   = palette_in_q;
    assign bus.wren_palette = wren_palette_q;
    assign bus.tx_byte      = tx_byte_q;

endmodule

// File: tb/tb_fb_write_engine.sv
// Directed testbench for fb_write_engine: a table of SPI byte sequences with
// their expected framebuffer/palette writes, plus hand-written status-read
// and reset-abort sequences.
module tb_fb_write_engine;

    localparam int ADDR_W      = 17;
    localparam int TB_FB_WORDS = 76800;
    localparam int NVEC        = 8;

    typedef struct packed {
        logic [3:0]             nbytes;
        logic [0:7][7:0]        bytes;
        logic [1:0]             exp_rgb_n;
        logic [0:1][ADDR_W-1:0] exp_rgb_addr;
        logic [0:1][7:0]        exp_rgb_data;
        logic [1:0]             exp_fd_n;
        logic [1:0]             exp_pal_n;
        logic [0:1][7:0]        exp_pal_addr;
        logic [0:1][23:0]       exp_pal_data;
    } vec_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic hblank = 1'b0;
    logic vblank = 1'b0;

    int total = 0;
    int bad   = 0;

    vec_t vecs [NVEC];

    logic [ADDR_W-1:0] ev_rgb_addr [$];
    logic [7:0]        ev_rgb_data [$];
    logic [7:0]        ev_pal_addr [$];
    logic [23:0]       ev_pal_data [$];
    int                fd_count      = 0;
    int                overlap_count = 0;

    int rgb_base;
    int pal_base;
    int fd_base;
    int ovl_base;

    always #5 clk = ~clk;

    fb_write_engine_if #(.ADDR_W(ADDR_W)) bus ();

    fb_write_engine #(
        .FB_WORDS (TB_FB_WORDS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .hblank (hblank),
        .vblank (vblank),
        .bus    (bus)
    );

    // Record every write strobe seen on the falling edge
    always @(negedge clk) begin
        if (bus.wren_rgb) begin
            ev_rgb_addr.push_back(bus.rgb_addr);
            ev_rgb_data.push_back(bus.rgb_in);
        end
        if (bus.wren_palette) begin
            ev_pal_addr.push_back(bus.palette_addr);
            ev_pal_data.push_back(bus.palette_in);
        end
        if (bus.frame_done) fd_count++;
        if (bus.wren_rgb && bus.wren_palette) overlap_count++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic markEvents();
        rgb_base = ev_rgb_addr.size();
        pal_base = ev_pal_addr.size();
        fd_base  = fd_count;
        ovl_base = overlap_count;
    endtask

    // Assumes the caller sits just after a rising edge
    task automatic sendByte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic endTransaction();
        bus.cs_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        markEvents();
        bus.cs_active = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < int'(v.nbytes); i++) sendByte(v.bytes[i]);
        endTransaction();
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        int n_rgb;
        int n_pal;
        n_rgb = ev_rgb_addr.size() - rgb_base;
        n_pal = ev_pal_addr.size() - pal_base;
        checkOutput($sformatf("v%0d rgb_count", idx), 32'(n_rgb), 32'(v.exp_rgb_n));
        for (int k = 0; k < 2; k++) begin
            if (k < int'(v.exp_rgb_n) && k < n_rgb) begin
                checkOutput($sformatf("v%0d rgb_addr[%0d]", idx, k), 32'(ev_rgb_addr[rgb_base + k]), 32'(v.exp_rgb_addr[k]));
                checkOutput($sformatf("v%0d rgb_data[%0d]", idx, k), 32'(ev_rgb_data[rgb_base + k]), 32'(v.exp_rgb_data[k]));
            end
        end
        checkOutput($sformatf("v%0d frame_done_count", idx), 32'(fd_count - fd_base), 32'(v.exp_fd_n));
        checkOutput($sformatf("v%0d pal_count", idx), 32'(n_pal), 32'(v.exp_pal_n));
        for (int k = 0; k < 2; k++) begin
            if (k < int'(v.exp_pal_n) && k < n_pal) begin
                checkOutput($sformatf("v%0d pal_addr[%0d]", idx, k), 32'(ev_pal_addr[pal_base + k]), 32'(v.exp_pal_addr[k]));
                checkOutput($sformatf("v%0d pal_data[%0d]", idx, k), 32'(ev_pal_data[pal_base + k]), 32'(v.exp_pal_data[k]));
            end
        end
        checkOutput($sformatf("v%0d strobe_overlap", idx), 32'(overlap_count - ovl_base), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rgb_addr"},     32'(bus.rgb_addr),     32'd0);
        checkOutput({tag, " rgb_in"},       32'(bus.rgb_in),       32'd0);
        checkOutput({tag, " wren_rgb"},     32'(bus.wren_rgb),     32'd0);
        checkOutput({tag, " palette_addr"}, 32'(bus.palette_addr), 32'd0);
        checkOutput({tag, " palette_in"},   32'(bus.palette_in),   32'd0);
        checkOutput({tag, " wren_palette"}, 32'(bus.wren_palette), 32'd0);
        checkOutput({tag, " tx_byte"},      32'(bus.tx_byte),      32'd0);
        checkOutput({tag, " frame_done"},   32'(bus.frame_done),   32'd0);
    endtask

    task automatic statusRead(input logic vb, input logic hb, input logic [7:0] exp);
        bit found;
        vblank = vb;
        hblank = hb;
        markEvents();
        repeat (4) @(posedge clk);
        #1;
        bus.cs_active = 1'b1;
        @(posedge clk); #1;
        checkOutput($sformatf("status%0h tx_before", exp), 32'(bus.tx_byte), 32'd0);
        bus.rx_byte  = 8'h03;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3 && !found; c++) begin
            @(negedge clk);
            if (bus.tx_byte == exp) found = 1'b1;
        end
        checkOutput($sformatf("status%0h tx_loaded", exp), 32'(bus.tx_byte), 32'(exp));
        @(posedge clk); #1;
        sendByte(8'h55);
        checkOutput($sformatf("status%0h tx_held", exp), 32'(bus.tx_byte), 32'(exp));
        endTransaction();
        checkOutput($sformatf("status%0h tx_cleared", exp), 32'(bus.tx_byte), 32'd0);
        checkOutput($sformatf("status%0h no_writes", exp),
                    32'((ev_rgb_addr.size() - rgb_base) + (ev_pal_addr.size() - pal_base)), 32'd0);
    endtask

    initial begin
        vec_t v;

        // Table of byte streams (bytes listed in send order) and expected writes
        vecs[0] = '{nbytes: 4'd6, bytes: {8'h01, 8'h00, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'h00, 8'h00},
                    exp_rgb_n: 2'd2, exp_rgb_addr: {17'd5, 17'd6}, exp_rgb_data: {8'hAA, 8'hBB},
                    exp_fd_n: 2'd0, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};
        vecs[1] = '{nbytes: 4'd6, bytes: {8'h01, 8'h01, 8'h2B, 8'hFF, 8'h11, 8'h22, 8'h00, 8'h00},
                    exp_rgb_n: 2'd2, exp_rgb_addr: {17'd76799, 17'd0}, exp_rgb_data: {8'h11, 8'h22},
                    exp_fd_n: 2'd1, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};
        vecs[2] = '{nbytes: 4'd8, bytes: {8'h02, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60},
                    exp_rgb_n: 2'd0, exp_rgb_addr: '0, exp_rgb_data: '0,
                    exp_fd_n: 2'd0, exp_pal_n: 2'd2, exp_pal_addr: {8'hFF, 8'h00},
                    exp_pal_data: {24'h102030, 24'h405060}};
        vecs[3] = '{nbytes: 4'd4, bytes: {8'h02, 8'h07, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00},
                    exp_rgb_n: 2'd0, exp_rgb_addr: '0, exp_rgb_data: '0,
                    exp_fd_n: 2'd0, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};
        vecs[4] = '{nbytes: 4'd5, bytes: {8'h01, 8'h00, 8'h00, 8'h09, 8'h5A, 8'h00, 8'h00, 8'h00},
                    exp_rgb_n: 2'd1, exp_rgb_addr: {17'd9, 17'd0}, exp_rgb_data: {8'h5A, 8'h00},
                    exp_fd_n: 2'd0, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};
        vecs[5] = '{nbytes: 4'd6, bytes: {8'h7E, 8'h01, 8'h00, 8'h00, 8'h05, 8'hAA, 8'h00, 8'h00},
                    exp_rgb_n: 2'd0, exp_rgb_addr: '0, exp_rgb_data: '0,
                    exp_fd_n: 2'd0, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};
        // 0x1FFFF is beyond the framebuffer: first byte suppressed, then natural wrap to 0
        vecs[6] = '{nbytes: 4'd6, bytes: {8'h01, 8'h01, 8'hFF, 8'hFF, 8'h99, 8'hAA, 8'h00, 8'h00},
                    exp_rgb_n: 2'd1, exp_rgb_addr: {17'd0, 17'd0}, exp_rgb_data: {8'hAA, 8'h00},
                    exp_fd_n: 2'd0, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};
        // Upper address bits beyond ADDR_W are dropped: 0xFE0007 -> 7
        vecs[7] = '{nbytes: 4'd5, bytes: {8'h01, 8'hFE, 8'h00, 8'h07, 8'hCC, 8'h00, 8'h00, 8'h00},
                    exp_rgb_n: 2'd1, exp_rgb_addr: {17'd7, 17'd0}, exp_rgb_data: {8'hCC, 8'h00},
                    exp_fd_n: 2'd0, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};

        bus.cs_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("post_reset");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i], i);
        end

        statusRead(1'b1, 1'b0, 8'h02);
        statusRead(1'b0, 1'b1, 8'h01);

        // Reset in the middle of a framebuffer burst
        vblank = 1'b0;
        hblank = 1'b0;
        bus.cs_active = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h10);
        bus.rx_byte  = 8'hAB;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        checkOutput("midreset wren_before", 32'(bus.wren_rgb), 32'd1);
        checkOutput("midreset addr_before", 32'(bus.rgb_addr), 32'h10);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        markEvents();
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h11);
        sendByte(8'hCD);
        checkOutput("midreset ignored_until_cs_idle", 32'(ev_rgb_addr.size() - rgb_base), 32'd0);
        endTransaction();

        v = '{nbytes: 4'd5, bytes: {8'h01, 8'h00, 8'h00, 8'h20, 8'hEE, 8'h00, 8'h00, 8'h00},
              exp_rgb_n: 2'd1, exp_rgb_addr: {17'h20, 17'd0}, exp_rgb_data: {8'hEE, 8'h00},
              exp_fd_n: 2'd0, exp_pal_n: 2'd0, exp_pal_addr: '0, exp_pal_data: '0};
        applyStimulus(v);
        checkVector(v, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
